wb_arbiter_decoder: RTL and testbench
=====================================

// Module: wb_arbiter_decoder
// PURPOSE
//  WISHBONE interconnect upstream of the bus terminator: two masters (M0 = ao68000 CPU, M1 = OCS DMA) arbitrate for one
//  shared bus, the granted cycle is decoded to one of NS address windows or the default port (the terminator).
//  Routes responses back to the granted master only. A watchdog ends stalled cycles with ERR.
// PARAMETERS
//  NS          4                      number of decoded slave windows (default port is index NS)
//  SLAVE_BASE  {NS{32'h0}}            packed NS x 32b window bases, slave i at [32*i +: 32]
//  SLAVE_MASK  {NS{32'hFFFFFFFF}}     packed NS x 32b masks; hit_i = ({ADR,2'b00} & MASK_i) == BASE_i
//  TIMEOUT     255                    cycles without ACK/ERR/RTY before watchdog ERR (1..65535)
// PORTS
//  CLK_I            in   1       system clock
//  reset            in   1       asynchronous, active-high reset
//  m_ADR_I          in   2x30    packed master addresses [31:2]; M0 at [29:0]
//  m_CYC_I/m_STB_I  in   2       per-master cycle / strobe
//  m_WE_I           in   2       per-master write enable
//  m_SEL_I          in   2x4     per-master byte selects
//  m_DAT_I          in   2x32    per-master write data
//  m_DAT_O          out  32      read data (broadcast; valid only with the granted master's ACK)
//  m_ACK_O/ERR_O/RTY_O out 2     per-master terminations
//  cpu_space_in     in   1       M0 interrupt-acknowledge (CPU space) indicator
//  s_ADR_O          out  30      shared slave address; s_WE_O 1, s_SEL_O 4, s_DAT_O 32 likewise shared
//  s_CYC_O/s_STB_O  out  NS+1    one-hot per slave; bit NS = default port
//  s_DAT_I          in   (NS+1)x32 slave read data
//  s_ACK_I/ERR_I/RTY_I in NS+1   slave terminations
//  cpu_space_cycle  out  1       to default port; = cpu_space_in when M0 granted, else 0
// BEHAVIOUR
//  Reset: state IDLE, grant none, last_grant = M1, watchdog 0; all s_CYC_O/s_STB_O, m_ACK/ERR/RTY_O = 0,
//   cpu_space_cycle = 0. Reset mid-cycle aborts it silently (no termination issued).
//  States: IDLE, BUS, TOUT, HOLD.
//  IDLE: nothing driven. If any m_CYC_I: grant registered next edge -> BUS (1-cycle arbitration latency).
//   Only one requester -> it wins. Both -> master != last_grant wins (round robin); last_grant updated on grant.
//  BUS: shared s_* driven from granted master; s_CYC_O[sel] = m_CYC, s_STB_O[sel] = m_STB, others 0.
//   sel decode combinational on granted address each cycle: lowest i with hit_i; no hit -> NS.
//   cpu_space_in=1 with M0 granted forces sel = NS (terminator answers IACK with RTY).
//   m_ACK/ERR/RTY_O[g] = s_*_I[sel] combinationally (zero added latency); other master's outputs 0.
//   m_DAT_O = s_DAT_I[sel].
//   Granted m_CYC_I = 0 -> IDLE next edge (bus released; one idle cycle between tenures even for same master).
//  Watchdog (BUS): count cleared when STB=0 or any termination; else +1. count == TIMEOUT-1 and no termination
//   -> TOUT next edge. TOUT: m_ERR_O[g] = 1 for exactly one cycle, all s_CYC/STB = 0 -> HOLD.
//   HOLD: slave side idle, late slave terminations ignored; leave to IDLE when granted m_CYC_I = 0.
//  Simultaneous termination and timeout on same cycle: termination wins, no ERR.
//  Non-granted master's CYC is ignored until IDLE; its requests are never lost (level-sensitive).
// STRUCTURE
//  Shared package: state encoding (IDLE/BUS/TOUT/HOLD), MASTER_CPU=0 / MASTER_DMA=1 constants, default-port index rule.
//  One sub-module: bus_timeout_counter (clear/enable/expire, width clog2(TIMEOUT+1)); decode and muxes stay inline.
// TESTING
//  1. M0 read 0x00DFF004 hits slave 1 (BASE 0x00DFF000, MASK 0xFFFFF000); slave ACKs 2 cycles later -> m_ACK_O[0]
//     same cycle, m_DAT_O = s_DAT_I[1], m_ACK_O[1]=0; slave CYC asserts 1 cycle after m_CYC_I.
//  2. M0 and M1 raise CYC same cycle after reset -> M0 granted first; on release M1 granted after 1 IDLE cycle;
//     repeated contention alternates M0,M1,M0.
//  3. M1 address 0x00F00000 matching no window -> s_CYC_O[NS]=1; terminator ACK routed to m_ACK_O[1].
//  4. M0 with cpu_space_in=1, ADR=30'h3FFFFFF8 -> default port selected, cpu_space_cycle=1, RTY -> m_RTY_O[0].
//  5. Slave never responds, TIMEOUT=8 -> m_ERR_O[g] pulses one cycle 8 cycles after STB, s_CYC_O drops; late
//     slave ACK ignored; IDLE after master drops CYC.
//  6. reset asserted during BUS -> all outputs 0 asynchronously; after release, contention again grants M0 first.

Source files
------------

// File: rtl/wb_arbiter_decoder_pkg.sv
// Shared definitions for the two-master WISHBONE arbiter/decoder: FSM encoding,
// master indices and the default-port index rule.
package wb_arbiter_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_TOUT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam logic MASTER_CPU = 1'b0;
  localparam logic MASTER_DMA = 1'b1;

  // The terminator always sits one past the last decoded window.
  function automatic int default_port(input int ns);
    return ns;
  endfunction

endpackage

// File: rtl/wb_arbiter_decoder_if.sv
// Bundle of master-side and slave-side WISHBONE signals around the arbiter/decoder.
// Handshake: a master holds CYC/STB until one of ACK/ERR/RTY terminates the access.
interface wb_arbiter_decoder_if #(
  parameter int NS = 4
);
  logic [59:0]            m_ADR_I;
  logic [1:0]             m_CYC_I;
  logic [1:0]             m_STB_I;
  logic [1:0]             m_WE_I;
  logic [7:0]             m_SEL_I;
  logic [63:0]            m_DAT_I;
  logic [31:0]            m_DAT_O;
  logic [1:0]             m_ACK_O;
  logic [1:0]             m_ERR_O;
  logic [1:0]             m_RTY_O;
  logic                   cpu_space_in;
  logic [29:0]            s_ADR_O;
  logic                   s_WE_O;
  logic [3:0]             s_SEL_O;
  logic [31:0]            s_DAT_O;
  logic [NS:0]            s_CYC_O;
  logic [NS:0]            s_STB_O;
  logic [(NS+1)*32-1:0]   s_DAT_I;
  logic [NS:0]            s_ACK_I;
  logic [NS:0]            s_ERR_I;
  logic [NS:0]            s_RTY_I;
  logic                   cpu_space_cycle;

  // The interconnect is a slave to the masters; the environment takes the other side.
  modport slave (
    input  m_ADR_I, m_CYC_I, m_STB_I, m_WE_I, m_SEL_I, m_DAT_I, cpu_space_in,
    input  s_DAT_I, s_ACK_I, s_ERR_I, s_RTY_I,
    output m_DAT_O, m_ACK_O, m_ERR_O, m_RTY_O,
    output s_ADR_O, s_WE_O, s_SEL_O, s_DAT_O, s_CYC_O, s_STB_O, cpu_space_cycle
  );

  modport master (
    output m_ADR_I, m_CYC_I, m_STB_I, m_WE_I, m_SEL_I, m_DAT_I, cpu_space_in,
    output s_DAT_I, s_ACK_I, s_ERR_I, s_RTY_I,
    input  m_DAT_O, m_ACK_O, m_ERR_O, m_RTY_O,
    input  s_ADR_O, s_WE_O, s_SEL_O, s_DAT_O, s_CYC_O, s_STB_O, cpu_space_cycle
  );
endinterface

// File: rtl/wb_arbiter_decoder_bus_timeout_counter.sv
// Watchdog counter: counts stalled strobe cycles and flags the last allowed one.
module wb_arbiter_decoder_bus_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign expire = (count == CW'(TIMEOUT - 1));
endmodule

// File: rtl/wb_arbiter_decoder.sv
// Two-master round-robin WISHBONE arbiter with address decode to NS windows plus a
// default port, combinational response routing and a stall watchdog.
module wb_arbiter_decoder
  import wb_arbiter_decoder_pkg::*;
#(
  parameter int              NS         = 4,
  parameter logic [NS*32-1:0] SLAVE_BASE = {NS{32'h0}},
  parameter logic [NS*32-1:0] SLAVE_MASK = {NS{32'hFFFF_FFFF}},
  parameter int              TIMEOUT    = 255
) (
  input  logic                 CLK_I,
  input  logic                 reset,
  wb_arbiter_decoder_if.slave  bus,
  output state_t               dbg_state
);
  localparam int SW       = $clog2(NS + 1);
  localparam int DEF_PORT = default_port(NS);

  state_t      state;
  logic        grant;
  logic        last_grant;
  logic        next_grant;
  logic [29:0] g_adr;
  logic        g_cyc, g_stb, g_we;
  logic [3:0]  g_sel;
  logic [31:0] g_dat;
  logic        iack;
  logic [SW-1:0] sel;
  logic        sel_ack, sel_err, sel_rty;
  logic [31:0] sel_dat;
  logic        in_bus, term, expire, timeout;

  always_comb begin
    g_adr = grant ? bus.m_ADR_I[59:30] : bus.m_ADR_I[29:0];
    g_cyc = bus.m_CYC_I[grant];
    g_stb = bus.m_STB_I[grant];
    g_we  = bus.m_WE_I[grant];
    g_sel = grant ? bus.m_SEL_I[7:4] : bus.m_SEL_I[3:0];
    g_dat = grant ? bus.m_DAT_I[63:32] : bus.m_DAT_I[31:0];
  end

  // Lowest matching window wins; CPU interrupt acknowledge always goes to the terminator.
  always_comb begin
    iack = (grant == MASTER_CPU) && bus.cpu_space_in;
    sel  = SW'(DEF_PORT);
    if (!iack) begin
      for (int i = NS - 1; i >= 0; i--) begin
        if (({g_adr, 2'b00} & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
          sel = SW'(i);
        end
      end
    end
  end

  always_comb begin
    sel_ack = 1'b0;
    sel_err = 1'b0;
    sel_rty = 1'b0;
    sel_dat = '0;
    for (int i = 0; i <= NS; i++) begin
      if (sel == SW'(i)) begin
        sel_ack = bus.s_ACK_I[i];
        sel_err = bus.s_ERR_I[i];
        sel_rty = bus.s_RTY_I[i];
        sel_dat = bus.s_DAT_I[32*i +: 32];
      end
    end
  end

  assign in_bus  = (state == ST_BUS);
  assign term    = in_bus && (sel_ack || sel_err || sel_rty);
  // A termination arriving on the expiry cycle takes precedence over the watchdog.
  assign timeout = in_bus && g_cyc && g_stb && !term && expire;

  wb_arbiter_decoder_bus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (CLK_I),
    .rst    (reset),
    .clear  (!in_bus || !g_stb || term),
    .enable (in_bus),
    .expire (expire)
  );

  always_comb begin
    if (bus.m_CYC_I == 2'b11) next_grant = ~last_grant;
    else                      next_grant = bus.m_CYC_I[MASTER_DMA] ? MASTER_DMA : MASTER_CPU;
  end

  always_ff @(posedge CLK_I or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      grant      <= MASTER_CPU;
      last_grant <= MASTER_DMA;
    end else begin
      case (state)
        ST_IDLE: if (|bus.m_CYC_I) begin
          grant      <= next_grant;
          last_grant <= next_grant;
          state      <= ST_BUS;
        end
        ST_BUS: begin
          if (!g_cyc)       state <= ST_IDLE;
          else if (timeout) state <= ST_TOUT;
        end
        ST_TOUT: state <= ST_HOLD;
        ST_HOLD: if (!g_cyc) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.s_CYC_O = '0;
    bus.s_STB_O = '0;
    for (int i = 0; i <= NS; i++) begin
      if (in_bus && (sel == SW'(i))) begin
        bus.s_CYC_O[i] = g_cyc;
        bus.s_STB_O[i] = g_stb;
      end
    end
    bus.s_ADR_O = in_bus ? g_adr : '0;
    bus.s_WE_O  = in_bus && g_we;
    bus.s_SEL_O = in_bus ? g_sel : '0;
    bus.s_DAT_O = in_bus ? g_dat : '0;
    bus.m_ACK_O = '0;
    bus.m_ERR_O = '0;
    bus.m_RTY_O = '0;
    if (in_bus) begin
      bus.m_ACK_O[grant] = sel_ack;
      bus.m_ERR_O[grant] = sel_err;
      bus.m_RTY_O[grant] = sel_rty;
    end
    if (state == ST_TOUT) bus.m_ERR_O[grant] = 1'b1;
    bus.m_DAT_O         = sel_dat;
    bus.cpu_space_cycle = in_bus && iack;
  end

  assign dbg_state = state;
endmodule

// File: tb/tb_wb_arbiter_decoder.sv
// Directed bench for wb_arbiter_decoder: decode, round robin, default port,
// CPU-space routing, watchdog and asynchronous reset.
module tb_wb_arbiter_decoder;
  import wb_arbiter_decoder_pkg::*;

  localparam int NS = 4;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t dbg_state;
  int     checks = 0;
  int     errors = 0;

  always #5 clk = ~clk;

  wb_arbiter_decoder_if #(.NS(NS)) bus ();

  wb_arbiter_decoder #(
    .NS         (NS),
    .SLAVE_BASE ({32'h00E0_0000, 32'h00C0_0000, 32'h00DF_F000, 32'h0000_0000}),
    .SLAVE_MASK ({32'hFFF0_0000, 32'hFFF0_0000, 32'hFFFF_F000, 32'hFFF0_0000}),
    .TIMEOUT    (8)
  ) dut (
    .CLK_I     (clk),
    .reset     (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive_m(input int m, input logic cyc, input logic [29:0] adr,
                         input logic we, input logic [3:0] sel, input logic [31:0] dat);
    bus.m_CYC_I[m]          = cyc;
    bus.m_STB_I[m]          = cyc;
    bus.m_WE_I[m]           = we;
    bus.m_ADR_I[30*m +: 30] = adr;
    bus.m_SEL_I[4*m +: 4]   = sel;
    bus.m_DAT_I[32*m +: 32] = dat;
  endtask

  task automatic clear_slaves();
    bus.s_ACK_I = '0;
    bus.s_ERR_I = '0;
    bus.s_RTY_I = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_m(0, 1'b0, '0, 1'b0, 4'h0, '0);
    drive_m(1, 1'b0, '0, 1'b0, 4'h0, '0);
    bus.cpu_space_in = 1'b0;
    clear_slaves();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    bus.s_DAT_I = {32'hD4D4_0004, 32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
    do_reset();
    settle();
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_scyc", bus.s_CYC_O, 5'b00000);
    chk("rst_sstb", bus.s_STB_O, 5'b00000);
    chk("rst_mterm", {bus.m_ACK_O, bus.m_ERR_O, bus.m_RTY_O}, 6'b000000);
    chk("rst_cpusp", bus.cpu_space_cycle, 1'b0);

    // M0 read of 0x00DFF004 -> slave 1
    step(); drive_m(0, 1'b1, 30'h0037_FC01, 1'b0, 4'hF, 32'h0); settle();
    chk("t1_arb_lat", bus.s_CYC_O, 5'b00000);
    step(); settle();
    chk("t1_scyc", bus.s_CYC_O, 5'b00010);
    chk("t1_sadr", bus.s_ADR_O, 30'h0037_FC01);
    chk("t1_noack", bus.m_ACK_O, 2'b00);
    step(); settle();
    chk("t1_wait", bus.m_ACK_O, 2'b00);
    step(); bus.s_ACK_I[1] = 1'b1; settle();
    chk("t1_ack", bus.m_ACK_O, 2'b01);
    chk("t1_dat", bus.m_DAT_O, 32'hD1D1_0001);
    step(); clear_slaves(); drive_m(0, 1'b0, 30'h0037_FC01, 1'b0, 4'hF, 32'h0); settle();
    chk("t1_drop", bus.s_CYC_O, 5'b00000);
    step(); settle();
    chk("t1_idle", dbg_state, ST_IDLE);

    // Contention after reset: M0, M1, M0
    do_reset();
    step();
    drive_m(0, 1'b1, 30'h0000_0040, 1'b0, 4'hF, 32'h0);
    drive_m(1, 1'b1, 30'h0030_0004, 1'b1, 4'hC, 32'hCAFE_F00D);
    settle();
    chk("t2_idle0", dbg_state, ST_IDLE);
    step(); bus.s_ACK_I[0] = 1'b1; settle();
    chk("t2_g0_scyc", bus.s_CYC_O, 5'b00001);
    chk("t2_g0_adr", bus.s_ADR_O, 30'h0000_0040);
    chk("t2_g0_ack", bus.m_ACK_O, 2'b01);
    step(); clear_slaves(); drive_m(0, 1'b0, 30'h0000_0040, 1'b0, 4'hF, 32'h0); settle();
    chk("t2_rel0", bus.s_CYC_O, 5'b00000);
    step(); drive_m(0, 1'b1, 30'h0000_0040, 1'b0, 4'hF, 32'h0); settle();
    chk("t2_gap", dbg_state, ST_IDLE);
    step(); bus.s_ACK_I[2] = 1'b1; settle();
    chk("t2_g1_scyc", bus.s_CYC_O, 5'b00100);
    chk("t2_g1_wr", {bus.s_WE_O, bus.s_SEL_O, bus.s_DAT_O}, {1'b1, 4'hC, 32'hCAFE_F00D});
    chk("t2_g1_ack", bus.m_ACK_O, 2'b10);
    step(); clear_slaves(); drive_m(1, 1'b0, 30'h0030_0004, 1'b1, 4'hC, 32'hCAFE_F00D); settle();
    step(); drive_m(1, 1'b1, 30'h0030_0004, 1'b1, 4'hC, 32'hCAFE_F00D); settle();
    chk("t2_gap2", dbg_state, ST_IDLE);
    step(); settle();
    chk("t2_g0_again", bus.s_CYC_O, 5'b00001);
    step(); drive_m(0, 1'b0, '0, 1'b0, 4'h0, '0); drive_m(1, 1'b0, '0, 1'b0, 4'h0, '0);
    step(); settle();
    chk("t2_end", dbg_state, ST_IDLE);

    // M1 unmapped address -> default port
    step(); drive_m(1, 1'b1, 30'h003C_0000, 1'b0, 4'hF, 32'h0);
    step(); settle();
    chk("t3_scyc", bus.s_CYC_O, 5'b10000);
    bus.s_ACK_I[4] = 1'b1; #1;
    chk("t3_ack", bus.m_ACK_O, 2'b10);
    chk("t3_dat", bus.m_DAT_O, 32'hD4D4_0004);
    step(); clear_slaves(); drive_m(1, 1'b0, '0, 1'b0, 4'h0, '0);
    step(); settle();
    chk("t3_idle", dbg_state, ST_IDLE);

    // CPU space acknowledge from M0; the same flag on M1 has no effect
    drive_m(0, 1'b1, 30'h3FFF_FFF8, 1'b0, 4'hF, 32'h0); bus.cpu_space_in = 1'b1;
    step(); settle();
    chk("t4_scyc", bus.s_CYC_O, 5'b10000);
    chk("t4_cpusp", bus.cpu_space_cycle, 1'b1);
    bus.s_RTY_I[4] = 1'b1; #1;
    chk("t4_rty", {bus.m_RTY_O, bus.m_ACK_O}, 4'b0100);
    step(); clear_slaves(); drive_m(0, 1'b0, '0, 1'b0, 4'h0, '0);
    step(); drive_m(1, 1'b1, 30'h0030_0004, 1'b0, 4'hF, 32'h0);
    step(); settle();
    chk("t4_m1_scyc", bus.s_CYC_O, 5'b00100);
    chk("t4_m1_cpusp", bus.cpu_space_cycle, 1'b0);
    step(); drive_m(1, 1'b0, '0, 1'b0, 4'h0, '0); bus.cpu_space_in = 1'b0;
    step(); settle();
    chk("t4_idle", dbg_state, ST_IDLE);

    // Watchdog on a silent slave 3
    step(); drive_m(0, 1'b1, 30'h0038_0000, 1'b0, 4'hF, 32'h0);
    step(); settle();
    chk("t5_scyc", bus.s_CYC_O, 5'b01000);
    for (int k = 1; k < 8; k++) begin
      step(); settle();
      chk("t5_quiet", {bus.m_ERR_O, bus.s_CYC_O}, {2'b00, 5'b01000});
    end
    step(); settle();
    chk("t5_err", bus.m_ERR_O, 2'b01);
    chk("t5_scyc_off", bus.s_CYC_O, 5'b00000);
    chk("t5_tout", dbg_state, ST_TOUT);
    step(); bus.s_ACK_I[3] = 1'b1; settle();
    chk("t5_late", {bus.m_ACK_O, bus.m_ERR_O}, 4'b0000);
    chk("t5_hold", dbg_state, ST_HOLD);
    step(); clear_slaves(); drive_m(0, 1'b0, '0, 1'b0, 4'h0, '0); settle();
    chk("t5_hold2", dbg_state, ST_HOLD);
    step(); settle();
    chk("t5_idle", dbg_state, ST_IDLE);

    // Reset in the middle of an M1 tenure
    step();
    drive_m(0, 1'b1, 30'h0000_0040, 1'b0, 4'hF, 32'h0);
    drive_m(1, 1'b1, 30'h0030_0004, 1'b0, 4'hF, 32'h0);
    step(); settle();
    chk("t6_m1", bus.s_CYC_O, 5'b00100);
    bus.s_ACK_I[2] = 1'b1; #1;
    chk("t6_ack", bus.m_ACK_O, 2'b10);
    rst = 1'b1; #1;
    chk("t6_rst_scyc", bus.s_CYC_O, 5'b00000);
    chk("t6_rst_ack", bus.m_ACK_O, 2'b00);
    chk("t6_rst_state", dbg_state, ST_IDLE);
    step(); step(); rst = 1'b0; clear_slaves(); settle();
    chk("t6_post", dbg_state, ST_IDLE);
    step(); settle();
    chk("t6_m0_first", bus.s_CYC_O, 5'b00001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
